// File: rtl/cfg_stream_pkg.sv
// Shared definitions for the fabric configuration word stream.
// Used by the transmit-side sender, the receiver-side FSM and the benches.
//   SYNC_WORD     : session sync pattern sent after ComActive rises
//   DESYNC_FLAG   : default header bit index that marks a desync word
//   desync_word() : builds the closing desync word for a given flag index
//   cfg_state_e   : sender FSM states
package cfg_stream_pkg;

    localparam logic [31:0] SYNC_WORD   = 32'hFAB0_FAB1;
    localparam int unsigned DESYNC_FLAG = 20;

    typedef enum logic [2:0] {
        StIdle,
        StActivate,
        StSync,
        StHeader,
        StData,
        StDesync,
        StDone
    } cfg_state_e;

    // All zeros except the desync flag bit.
    function automatic logic [31:0] desync_word(input int unsigned flag);
        return 32'd1 << flag;
    endfunction

endpackage

// File: rtl/config_bitstream_sender_if.sv
// Source-side bus between the on-chip config master and the bitstream sender.
//   FrameAddr/FrameAddrValid/FrameAddrReady : per-frame header word handshake
//   RowData/RowDataValid/RowDataReady       : row-data word handshake
//   RowIndex                                : row targeted by the next RowData word
// modport master: the config master (drives data/valid, sees ready/index)
// modport slave : the sender (drives ready/index, sees data/valid)
interface config_bitstream_sender_if #(
    parameter int unsigned RowSelectWidth = 5
);
    logic [31:0]               FrameAddr;
    logic                      FrameAddrValid;
    logic                      FrameAddrReady;
    logic [31:0]               RowData;
    logic                      RowDataValid;
    logic                      RowDataReady;
    logic [RowSelectWidth-1:0] RowIndex;

    modport master (
        output FrameAddr,
        output FrameAddrValid,
        input  FrameAddrReady,
        output RowData,
        output RowDataValid,
        input  RowDataReady,
        input  RowIndex
    );

    modport slave (
        input  FrameAddr,
        input  FrameAddrValid,
        output FrameAddrReady,
        input  RowData,
        input  RowDataValid,
        output RowDataReady,
        output RowIndex
    );
endinterface

// File: rtl/cfg_word_out_reg.sv
// Registered output stage for the config word stream.
//   CLK, resetn   : clock, synchronous active-low reset
//   load_i        : a word is emitted this cycle
//   word_i        : word to emit
//   write_data_o  : registered word; holds its last value when nothing is emitted
//   write_strobe_o: one-cycle strobe per emitted word
module cfg_word_out_reg (
    input  logic        CLK,
    input  logic        resetn,
    input  logic        load_i,
    input  logic [31:0] word_i,
    output logic [31:0] write_data_o,
    output logic        write_strobe_o
);

    logic [31:0] data_q;
    logic        strobe_q;

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            data_q   <= '0;
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= load_i;
            if (load_i) begin
                data_q <= word_i;
            end
        end
    end

    assign write_data_o   = data_q;
    assign write_strobe_o = strobe_q;

endmodule

// File: rtl/config_bitstream_sender.sv
// Transmit-side generator of the fabric configuration word stream:
// ComActive edge, sync word, per frame a header plus NumberOfRows row words,
// then a closing desync word.
//   CLK, resetn    : clock, synchronous active-low reset
//   Start          : begin a session (ignored while Busy)
//   FrameCount     : frames in the session, sampled on an accepted Start
//   Abort          : stop at the next frame boundary
//   src            : header / row-data source handshakes and RowIndex
//   Pace           : downstream accepts a word this cycle
//   WriteData/WriteStrobe : registered config word and its strobe
//   ComActive, Busy, Done, HeaderErr : session status
module config_bitstream_sender
    import cfg_stream_pkg::*;
#(
    parameter int unsigned NumberOfRows    = 16,
    parameter int unsigned RowSelectWidth  = 5,
    parameter int unsigned desync_flag     = DESYNC_FLAG,
    parameter logic [31:0] SyncWord        = SYNC_WORD,
    parameter int unsigned FrameCountWidth = 16
) (
    input  logic                       CLK,
    input  logic                       resetn,
    input  logic                       Start,
    input  logic [FrameCountWidth-1:0] FrameCount,
    input  logic                       Abort,
    config_bitstream_sender_if.slave   src,
    input  logic                       Pace,
    output logic [31:0]                WriteData,
    output logic                       WriteStrobe,
    output logic                       ComActive,
    output logic                       Busy,
    output logic                       Done,
    output logic                       HeaderErr
);

    localparam logic [31:0] DesyncMask = desync_word(desync_flag);

    cfg_state_e                 state_q, state_d;
    logic [FrameCountWidth-1:0] frames_q, frames_d;
    logic [RowSelectWidth-1:0]  rows_q, rows_d;
    logic                       abort_q, abort_d;
    logic                       herr_q, herr_d;
    logic                       emit;
    logic [31:0]                emit_word;

    // State register and datapath counters.
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state_q  <= StIdle;
            frames_q <= '0;
            rows_q   <= '0;
            abort_q  <= 1'b0;
            herr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            frames_q <= frames_d;
            rows_q   <= rows_d;
            abort_q  <= abort_d;
            herr_q   <= herr_d;
        end
    end

    // Next state, counter updates and the word selected for this slot.
    always_comb begin
        state_d   = state_q;
        frames_d  = frames_q;
        rows_d    = rows_q;
        herr_d    = herr_q;
        abort_d   = abort_q | (Abort & (state_q != StIdle));
        emit      = 1'b0;
        emit_word = '0;
        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    state_d  = StActivate;
                    frames_d = FrameCount;
                    herr_d   = 1'b0;
                    abort_d  = Abort;
                end
            end
            StActivate: state_d = StSync;
            StSync: begin
                if (Pace) begin
                    emit      = 1'b1;
                    emit_word = SyncWord;
                    state_d   = (frames_q == '0 || abort_q) ? StDesync : StHeader;
                end
            end
            StHeader: begin
                if (Pace) begin
                    if (abort_q) begin
                        state_d = StDesync;
                    end else if (src.FrameAddrValid) begin
                        emit      = 1'b1;
                        emit_word = src.FrameAddr & ~DesyncMask;
                        if ((src.FrameAddr & DesyncMask) != '0) begin
                            herr_d = 1'b1;
                        end
                        rows_d  = RowSelectWidth'(NumberOfRows);
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (Pace && src.RowDataValid) begin
                    emit      = 1'b1;
                    emit_word = src.RowData;
                    rows_d    = (rows_q != '0) ? rows_q - RowSelectWidth'(1) : '0;
                    if (rows_q == RowSelectWidth'(1)) begin
                        frames_d = (frames_q != '0) ? frames_q - FrameCountWidth'(1) : '0;
                        // More frames remain after this one only if at least two were left.
                        state_d  = (frames_q > FrameCountWidth'(1)) ? StHeader : StDesync;
                    end
                end
            end
            StDesync: begin
                if (Pace) begin
                    emit      = 1'b1;
                    emit_word = DesyncMask;
                    state_d   = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        Busy               = (state_q != StIdle);
        ComActive          = state_q inside {StActivate, StSync, StHeader, StData, StDesync};
        Done               = (state_q == StDone);
        HeaderErr          = herr_q;
        src.FrameAddrReady = (state_q == StHeader) & Pace & ~abort_q & src.FrameAddrValid;
        src.RowDataReady   = (state_q == StData) & Pace & src.RowDataValid;
        // All ones marks "no row" whenever row data is not being consumed, including after reset.
        src.RowIndex       = (state_q == StData) ? rows_q : '1;
    end

    cfg_word_out_reg u_word_out (
        .CLK            (CLK),
        .resetn         (resetn),
        .load_i         (emit),
        .word_i         (emit_word),
        .write_data_o   (WriteData),
        .write_strobe_o (WriteStrobe)
    );

endmodule
